// File: rtl/alu_seq_core.sv
// Multi-cycle signed ALU responder: single-cycle logic/add ops, iterative shift-add MUL and
// restoring DIV/MOD on operand magnitudes, with a level-start / one-cycle ready handshake.
module alu_seq_core #(
    parameter int unsigned N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [3:0]     opcode,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           ready,
    output logic           busy,
    output logic [2*N-1:0] result,
    output logic           Z,
    output logic           C,
    output logic           V,
    output logic           S,
    output logic           E
);

    localparam int unsigned W  = 2 * N;
    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] LastIt = CW'(N - 1);

    typedef enum logic [1:0] {StIdle, StMulIt, StDivIt, StFin} state_e;

    state_e         state_q;
    logic [3:0]     op_q;
    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;
    logic [W-1:0]   acc_q;   // MUL partial product, DIV/MOD partial remainder
    logic [W-1:0]   wa_q;    // MUL shifted multiplicand, DIV dividend/quotient in low N bits
    logic [N-1:0]   wb_q;    // MUL multiplier, DIV divisor
    logic [CW-1:0]  cnt_q;

    function automatic logic [N-1:0] mag(input logic [N-1:0] x);
        return x[N-1] ? (~x + 1'b1) : x;
    endfunction

    // One iteration of each sequential algorithm
    logic [W-1:0] mul_acc;
    logic [W-1:0] rem_sh;
    logic [W-1:0] rem_nxt;
    logic         rem_ge;

    always_comb begin
        mul_acc = wb_q[0] ? acc_q + wa_q : acc_q;
        rem_sh  = {acc_q[W-2:0], wa_q[N-1]};
        rem_ge  = rem_sh >= {{N{1'b0}}, wb_q};
        rem_nxt = rem_ge ? rem_sh - {{N{1'b0}}, wb_q} : rem_sh;
    end

    // Final result and flags from the latched request and iteration state
    logic [W-1:0] a_ext;
    logic [W-1:0] b_ext;
    logic [W-1:0] quo_ext;
    logic [W-1:0] fin_res;
    logic [N-1:0] nres;
    logic         neg_ab;
    logic         is_arith;
    logic         fin_c;
    logic         fin_v;
    logic         fin_e;

    always_comb begin
        a_ext    = {{N{a_q[N-1]}}, a_q};
        b_ext    = {{N{b_q[N-1]}}, b_q};
        quo_ext  = {{N{1'b0}}, wa_q[N-1:0]};
        neg_ab   = a_q[N-1] ^ b_q[N-1];
        nres     = '0;
        fin_res  = '0;
        fin_c    = 1'b0;
        fin_e    = 1'b0;
        is_arith = 1'b0;
        case (op_q)
            4'h0: begin
                fin_res  = a_ext + b_ext;
                fin_c    = a_q > ~b_q;  // unsigned A+B overflows iff A > (2^N-1)-B
                is_arith = 1'b1;
            end
            4'h1: begin
                fin_res  = a_ext - b_ext;
                fin_c    = a_q < b_q;
                is_arith = 1'b1;
            end
            4'h2: begin
                fin_res  = neg_ab ? -acc_q : acc_q;
                is_arith = 1'b1;
            end
            4'h3: begin
                if (b_q == '0) begin
                    fin_e = 1'b1;
                end else begin
                    fin_res  = neg_ab ? -quo_ext : quo_ext;
                    is_arith = 1'b1;
                end
            end
            4'h4: begin
                if (b_q == '0) fin_e = 1'b1;
                else           fin_res = a_q[N-1] ? -acc_q : acc_q;
            end
            4'h5:    nres = a_q & b_q;
            4'h6:    nres = a_q | b_q;
            4'h7:    nres = a_q ^ b_q;
            4'h8:    nres = ~a_q;
            4'h9:    nres = a_q << b_q[2:0];
            4'hA:    nres = $signed(a_q) >>> b_q[2:0];
            default: fin_e = 1'b1;
        endcase
        if (op_q >= 4'h5 && op_q <= 4'hA) fin_res = {{N{nres[N-1]}}, nres};
        fin_v = is_arith && !((&fin_res[W-1:N-1]) || !(|fin_res[W-1:N-1]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ready   <= 1'b0;
            busy    <= 1'b0;
            result  <= '0;
            Z       <= 1'b1;
            C       <= 1'b0;
            V       <= 1'b0;
            S       <= 1'b0;
            E       <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            wa_q    <= '0;
            wb_q    <= '0;
            cnt_q   <= '0;
        end else begin
            ready <= 1'b0;
            case (state_q)
                StIdle: begin
                    busy <= start;
                    if (start) begin
                        op_q  <= opcode;
                        a_q   <= A;
                        b_q   <= B;
                        cnt_q <= '0;
                        acc_q <= '0;
                        wa_q  <= {{N{1'b0}}, mag(A)};
                        wb_q  <= mag(B);
                        if (opcode == 4'h2) begin
                            state_q <= StMulIt;
                        end else if ((opcode == 4'h3 || opcode == 4'h4) && B != '0) begin
                            state_q <= StDivIt;
                        end else begin
                            state_q <= StFin;
                        end
                    end
                end
                StMulIt: begin
                    acc_q <= mul_acc;
                    wa_q  <= wa_q << 1;
                    wb_q  <= wb_q >> 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastIt) state_q <= StFin;
                end
                StDivIt: begin
                    acc_q <= rem_nxt;
                    wa_q  <= {{N{1'b0}}, wa_q[N-2:0], rem_ge};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastIt) state_q <= StFin;
                end
                StFin: begin
                    ready   <= 1'b1;
                    result  <= fin_res;
                    Z       <= (fin_res == '0);
                    C       <= fin_c;
                    V       <= fin_v;
                    S       <= fin_res[W-1];
                    E       <= fin_e;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
